// File: rtl/fm_out_pkg.sv
// Shared types and constants for the FM output conditioner.
// Optional build macro: FM_OUT_SOFT_MUTE_EN (gain ramp / soft mute).
package fm_out_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DCB  = 2'd1,
        MUL  = 2'd2,
        SAT  = 2'd3
    } fm_state_e;

    localparam logic [7:0] UNITY_GAIN     = 8'd128;
    localparam int         GAIN_FRAC_BITS = 7;
    localparam int         MUL_STEPS      = 8;

endpackage

// File: rtl/fm_serial_mul.sv
// Serial signed x unsigned 8-bit shift-add multiplier, one gain bit per cycle.
// done is high during the final accumulate cycle; product is valid after that edge.
module fm_serial_mul
    import fm_out_pkg::*;
#(
    parameter int A_WIDTH = 18,
    parameter int P_WIDTH = 26
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic signed [A_WIDTH-1:0] a,
    input  logic        [7:0]         b,
    output logic signed [P_WIDTH-1:0] product,
    output logic                      done
);

    logic signed [P_WIDTH-1:0] a_q, a_d;
    logic signed [P_WIDTH-1:0] acc_q, acc_d;
    logic        [7:0]         b_q, b_d;
    logic        [2:0]         step_q, step_d;
    logic                      active_q, active_d;

    // Load operands on start, then add the shifted multiplicand for each set gain bit, LSB first.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        step_d   = step_q;
        active_d = active_q;
        if (start) begin
            a_d      = {{(P_WIDTH-A_WIDTH){a[A_WIDTH-1]}}, a};
            b_d      = b;
            acc_d    = '0;
            step_d   = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (b_q[step_q]) begin
                acc_d = acc_q + (a_q <<< step_q);
            end
            step_d = step_q + 3'd1;
            if (step_q == 3'(MUL_STEPS - 1)) begin
                active_d = 1'b0;
            end
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            step_q   <= '0;
            active_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
            active_q <= active_d;
        end
    end

    assign product = acc_q;
    assign done    = active_q && (step_q == 3'(MUL_STEPS - 1));

endmodule

// File: rtl/fm_out_conditioner.sv
// Final FM audio stage: DC blocker, serial volume multiply, saturation.
// Optional build macro: FM_OUT_SOFT_MUTE_EN (gain ramps toward volume by 1 per sample).
module fm_out_conditioner
    import fm_out_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int DCB_SHIFT  = 10
) (
    input  logic                         clk_27m,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    input  logic                         sample_stb,
    input  logic        [7:0]            volume,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int YW        = DATA_WIDTH + 2;
    localparam int AW        = DATA_WIDTH + 10;
    localparam int SAT_SHIFT = GAIN_FRAC_BITS + DATA_WIDTH - OUT_WIDTH;
    localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    fm_state_e                   state_q, state_d;
    logic signed [DATA_WIDTH-1:0] x_q, x_d;
    logic signed [DATA_WIDTH-1:0] x1_q, x1_d;
    logic signed [YW-1:0]         y1_q, y1_d;
    logic        [7:0]            gain_q, gain_d;
    logic signed [OUT_WIDTH-1:0]  out_q, out_d;
    logic                         valid_q, valid_d;
    logic                         overrun_q, overrun_d;
    logic        [7:0]            gain_sel;
    logic signed [YW-1:0]         y_d;
    logic signed [AW-1:0]         product;
    logic signed [AW-1:0]         r;
    logic signed [OUT_WIDTH-1:0]  sat;
    logic                         mul_start;
    logic                         mul_done;

`ifdef FM_OUT_SOFT_MUTE_EN
    logic [7:0] ramp_q, ramp_d;

    // Step the effective gain one count toward volume on each accepted sample.
    always_comb begin
        ramp_d = ramp_q;
        if (state_q == IDLE && sample_stb) begin
            if (ramp_q < volume) begin
                ramp_d = ramp_q + 8'd1;
            end else if (ramp_q > volume) begin
                ramp_d = ramp_q - 8'd1;
            end
        end
        gain_sel = ramp_d;
    end

    // Ramp register starts at zero so output fades in after reset.
    always_ff @(posedge clk_27m or posedge reset) begin
        if (reset) begin
            ramp_q <= '0;
        end else begin
            ramp_q <= ramp_d;
        end
    end
`else
    assign gain_sel = volume;
`endif

    // DC blocker difference equation and output clamp.
    always_comb begin
        y_d = {{2{x_q[DATA_WIDTH-1]}}, x_q}
            - {{2{x1_q[DATA_WIDTH-1]}}, x1_q}
            + y1_q
            - (y1_q >>> DCB_SHIFT);
        r = product >>> SAT_SHIFT;
        if (r > SAT_MAX) begin
            sat = SAT_MAX[OUT_WIDTH-1:0];
        end else if (r < SAT_MIN) begin
            sat = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            sat = r[OUT_WIDTH-1:0];
        end
    end

    // Sequencer: IDLE -> DCB -> MUL x8 -> SAT -> IDLE, plus sticky overrun.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        gain_d    = gain_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        mul_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sample_stb) begin
                    x_d     = sample_in;
                    gain_d  = gain_sel;
                    state_d = DCB;
                end
            end
            DCB: begin
                mul_start = 1'b1;
                x1_d      = x_q;
                y1_d      = y_d;
                state_d   = MUL;
            end
            MUL: begin
                if (mul_done) begin
                    state_d = SAT;
                end
            end
            SAT: begin
                out_d   = sat;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (sample_stb && state_q != IDLE) begin
            overrun_d = 1'b1;
        end
    end

    // Conditioner state registers.
    always_ff @(posedge clk_27m or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            x_q       <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            gain_q    <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            gain_q    <= gain_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    fm_serial_mul #(
        .A_WIDTH (YW),
        .P_WIDTH (AW)
    ) u_mul (
        .clk     (clk_27m),
        .rst     (reset),
        .start   (mul_start),
        .a       (y_d),
        .b       (gain_q),
        .product (product),
        .done    (mul_done)
    );

    assign out_data  = out_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fm_out_conditioner.sv
// Directed bench for fm_out_conditioner (default build, soft mute disabled).
module tb_fm_out_conditioner;

    logic               clk_27m = 1'b0;
    logic               reset   = 1'b1;
    logic signed [15:0] sample_in  = '0;
    logic               sample_stb = 1'b0;
    logic        [7:0]  volume     = '0;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               busy;
    logic               overrun;

    int checks   = 0;
    int failures = 0;

    fm_out_conditioner dut (
        .clk_27m    (clk_27m),
        .reset      (reset),
        .sample_in  (sample_in),
        .sample_stb (sample_stb),
        .volume     (volume),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk_27m = ~clk_27m;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        sample_stb = 1'b0;
        repeat (2) @(posedge clk_27m);
        #1 reset = 1'b0;
    endtask

    // Strobe one sample, wait (bounded) for out_valid, check latency and value.
    task automatic send(input int x, input int v, input int exp, input string tag);
        int n;
        sample_in  = 16'(x);
        volume     = 8'(v);
        sample_stb = 1'b1;
        @(posedge clk_27m);
        #1 sample_stb = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk_27m);
            #1 n++;
        end
        chk({tag, "_latency"}, n, 11);
        chk({tag, "_data"}, int'(out_data), exp);
    endtask

    initial begin
        int ym;
        int x1m;
        int nv;
        int dv;

        // Reset values
        do_reset();
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);

        // First sample: unity gain, cycle-accurate busy/out_valid
        sample_in  = 16'sd1000;
        volume     = 8'd128;
        sample_stb = 1'b1;
        @(posedge clk_27m);
        #1 sample_stb = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            chk($sformatf("busy_c%0d", k), int'(busy), (k <= 10) ? 1 : 0);
            chk($sformatf("valid_c%0d", k), int'(out_valid), (k == 11) ? 1 : 0);
            if (k < 11) begin
                @(posedge clk_27m);
                #1;
            end
        end
        chk("unity_data", int'(out_data), 1000);
        @(posedge clk_27m);
        #1;
        chk("valid_c12", int'(out_valid), 0);
        chk("hold_data", int'(out_data), 1000);

        // Constant input decays through the DC blocker; floor shift stalls at 1023
        do_reset();
        ym  = 0;
        x1m = 0;
        for (int s = 0; s < 3500; s++) begin
            ym  = 8000 - x1m + ym - (ym >>> 10);
            x1m = 8000;
            send(8000, 128, ym, $sformatf("dcb_s%0d", s));
        end
        chk("dcb_final", int'(out_data), 1023);

        // Saturation at full gain, back-to-back strobes, zero volume
        do_reset();
        send(32767, 255, 32767, "clamp_pos");
        send(-32768, 255, -32768, "clamp_neg");
        send(0, 0, 0, "vol_zero");

        // Strobe while busy is dropped; volume change mid-sample is ignored
        do_reset();
        sample_in  = 16'sd100;
        volume     = 8'd128;
        sample_stb = 1'b1;
        @(posedge clk_27m);
        #1 sample_stb = 1'b0;
        nv = 0;
        dv = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) volume = 8'd0;
            if (k == 5) begin
                sample_in  = 16'sd5000;
                sample_stb = 1'b1;
            end
            if (k == 6) sample_stb = 1'b0;
            if (out_valid === 1'b1) begin
                nv++;
                dv = int'(out_data);
            end
            @(posedge clk_27m);
            #1;
        end
        chk("ovr_valid_count", nv, 1);
        chk("ovr_data", dv, 100);
        chk("ovr_flag", int'(overrun), 1);
        send(100, 128, 100, "ovr_next");
        chk("ovr_sticky", int'(overrun), 1);
        do_reset();
        chk("ovr_cleared", int'(overrun), 0);

        // Reset in the middle of a sample discards it and clears DC-blocker state
        send(2048, 128, 2048, "pre_abort");
        sample_in  = 16'sd0;
        volume     = 8'd128;
        sample_stb = 1'b1;
        @(posedge clk_27m);
        #1 sample_stb = 1'b0;
        repeat (5) begin
            @(posedge clk_27m);
            #1;
        end
        reset = 1'b1;
        #2;
        chk("abort_out_data", int'(out_data), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_overrun", int'(overrun), 0);
        @(posedge clk_27m);
        #1 reset = 1'b0;
        nv = 0;
        for (int k = 0; k < 15; k++) begin
            if (out_valid === 1'b1) nv++;
            @(posedge clk_27m);
            #1;
        end
        chk("abort_no_valid", nv, 0);
        send(1000, 128, 1000, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
